// File: rtl/lampFPU_pkg.sv
// Shared types and helpers for the lampFPU integer-to-float pipeline.
package lampFPU_pkg;

  typedef enum logic {
    RND_RNE = 1'b0,
    RND_RTZ = 1'b1
  } rnd_mode_e;

  // Per-operation control bits that travel alongside the datapath stage registers.
  typedef struct packed {
    logic      sign;
    logic      zero;
    rnd_mode_e rnd;
  } op_ctrl_t;

  function automatic int FUNC_bias(input int e_dw);
    return (1 << (e_dw - 1)) - 1;
  endfunction

endpackage

// File: rtl/lamp_fpu_lzc.sv
// Combinational leading-zero counter; cnt_o is meaningless when all_zero_o is set.
module lamp_fpu_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]         in_i,
  output logic [$clog2(W)-1:0] cnt_o,
  output logic                 all_zero_o
);

  localparam int CW = $clog2(W);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
    all_zero_o = ~|in_i;
  end

endmodule

// File: rtl/lamp_fpu_i2f_pipe.sv
// Three-stage integer-to-float converter (decode, normalise, round/pack) with
// valid/ready handshake and a single global stall.
module lamp_fpu_i2f_pipe
  import lampFPU_pkg::*;
#(
  parameter int INT_DW = 32,
  parameter int E_DW   = 8,
  parameter int F_DW   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [INT_DW-1:0]      op_i,
  input  logic                   signed_i,
  input  logic                   rnd_rtz_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [E_DW+F_DW:0]     res_o,
  output logic                   inexact_o,
  output logic                   overflow_o
);

  localparam int LZ_W  = $clog2(INT_DW);
  localparam int EXP_W = E_DW + LZ_W + 2;
  localparam int TW    = INT_DW + F_DW;
  localparam int BIAS  = FUNC_bias(E_DW);

  typedef struct packed {
    op_ctrl_t          ctrl;
    logic [INT_DW-1:0] mag;
  } s1_t;

  typedef struct packed {
    op_ctrl_t         ctrl;
    logic [EXP_W-1:0] exp;
    logic [F_DW-1:0]  frac;
    logic             g;
    logic             s;
  } s2_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  logic v1_q, v2_q, out_valid_q;
  logic [E_DW+F_DW:0] res_q, res_d;
  logic inexact_q, inexact_d, overflow_q, overflow_d;
  logic adv;

  assign adv         = ~out_valid_q | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign res_o       = res_q;
  assign inexact_o   = inexact_q;
  assign overflow_o  = overflow_q;

  // S1: sign/magnitude decode; the most negative value maps to its unsigned magnitude.
  logic op_neg;
  assign op_neg = signed_i & op_i[INT_DW-1];

  always_comb begin
    s1_d           = '0;
    s1_d.ctrl.sign = op_neg;
    s1_d.ctrl.zero = (op_i == '0);
    s1_d.ctrl.rnd  = rnd_mode_e'(rnd_rtz_i);
    s1_d.mag       = op_neg ? (~op_i + 1'b1) : op_i;
  end

  // S2: normalise so the hidden one is dropped; zero padding covers narrow integers.
  logic [LZ_W-1:0]   lz;
  logic              lz_all_zero;
  logic [INT_DW-2:0] nrm_lo;
  logic [TW-1:0]     frac_x;

  lamp_fpu_lzc #(.W(INT_DW)) u_lzc (
    .in_i       (s1_q.mag),
    .cnt_o      (lz),
    .all_zero_o (lz_all_zero)
  );

  assign nrm_lo = (INT_DW-1)'(s1_q.mag << lz);
  assign frac_x = {nrm_lo, {(F_DW+1){1'b0}}};

  always_comb begin
    s2_d           = '0;
    s2_d.ctrl      = s1_q.ctrl;
    s2_d.ctrl.zero = s1_q.ctrl.zero | lz_all_zero;
    s2_d.exp       = EXP_W'(INT_DW - 1 + BIAS) - EXP_W'(lz);
    s2_d.frac      = frac_x[TW-1 -: F_DW];
    s2_d.g         = frac_x[TW-1-F_DW];
    s2_d.s         = |frac_x[TW-2-F_DW:0];
  end

  // S3: round, propagate mantissa carry into the exponent, then saturate to infinity.
  logic            inc, carry;
  logic [F_DW-1:0] frac_r;
  logic [EXP_W-1:0] exp_r;

  always_comb begin
    inc           = (s2_q.ctrl.rnd == RND_RNE) & s2_q.g & (s2_q.frac[0] | s2_q.s);
    {carry, frac_r} = {1'b0, s2_q.frac} + (F_DW+1)'(inc);
    exp_r         = s2_q.exp + EXP_W'(carry);
    res_d         = '0;
    inexact_d     = 1'b0;
    overflow_d    = 1'b0;
    if (s2_q.ctrl.zero) begin
      res_d = '0;
    end else if (exp_r >= EXP_W'((1 << E_DW) - 1)) begin
      res_d      = {s2_q.ctrl.sign, {E_DW{1'b1}}, {F_DW{1'b0}}};
      inexact_d  = 1'b1;
      overflow_d = 1'b1;
    end else begin
      res_d     = {s2_q.ctrl.sign, exp_r[E_DW-1:0], frac_r};
      inexact_d = s2_q.g | s2_q.s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      res_q       <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (adv) begin
      v1_q        <= in_valid_i;
      s1_q        <= s1_d;
      v2_q        <= v1_q;
      s2_q        <= s2_d;
      out_valid_q <= v2_q;
      res_q       <= res_d;
      inexact_q   <= inexact_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_lamp_fpu_i2f_pipe.sv
// Directed and randomised checks of the i2f pipeline: bf16 instance (A) and a
// narrow-exponent half-precision instance (B) for overflow cases.
module tb_lamp_fpu_i2f_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [31:0] op = '0;
  logic sgn = 1'b0, rtz = 1'b0, out_ready = 1'b1;

  logic ir_a, ov_a, inx_a, ovf_a;
  logic ir_b, ov_b, inx_b, ovf_b;
  logic [15:0] res_a, res_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lamp_fpu_i2f_pipe #(.INT_DW(32), .E_DW(8), .F_DW(7)) dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_a), .in_ready_o(ir_a), .op_i(op),
    .signed_i(sgn), .rnd_rtz_i(rtz), .out_valid_o(ov_a), .out_ready_i(out_ready),
    .res_o(res_a), .inexact_o(inx_a), .overflow_o(ovf_a)
  );

  lamp_fpu_i2f_pipe #(.INT_DW(32), .E_DW(5), .F_DW(10)) dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_b), .in_ready_o(ir_b), .op_i(op),
    .signed_i(sgn), .rnd_rtz_i(rtz), .out_valid_o(ov_b), .out_ready_i(out_ready),
    .res_o(res_b), .inexact_o(inx_b), .overflow_o(ovf_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bench-side reference for the bf16 instance: explicit remainder vs. half-ulp rounding.
  function automatic logic [17:0] model(input logic [31:0] v, input logic s, input logic r);
    logic neg;
    logic [31:0] m, rem, half;
    logic [32:0] q;
    int p, e, sh;
    logic inx;
    neg = s & v[31];
    m = neg ? (32'd0 - v) : v;
    if (m == 32'd0) return 18'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = p + 127;
    inx = 1'b0;
    if (p <= 7) begin
      q = 33'(m) << (7 - p);
    end else begin
      sh = p - 7;
      q = 33'(m >> sh);
      rem = m & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      inx = (rem != 32'd0);
      if (!r && (rem > half || (rem == half && q[0]))) q = q + 33'd1;
      if (q == 33'd256) begin
        q = 33'd128;
        e = e + 1;
      end
    end
    return {1'b0, inx, neg, 8'(e), q[6:0]};
  endfunction

  // One isolated operation: checks 3-cycle latency and the packed result/flags.
  task automatic do_op(input logic sel, input logic [31:0] v, input logic s, input logic r,
                       input logic [15:0] e_res, input logic e_inx, input logic e_ovf,
                       input string tag);
    int n;
    logic got;
    @(negedge clk);
    op = v; sgn = s; rtz = r; out_ready = 1'b1;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    n = 1; got = 1'b0;
    while (!got && n < 10) begin
      if (sel ? ov_b : ov_a) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk({tag, ".lat"}, n, 3);
    if (got) begin
      chk({tag, ".res"}, sel ? res_b : res_a, e_res);
      chk({tag, ".inx"}, sel ? inx_b : inx_a, e_inx);
      chk({tag, ".ovf"}, sel ? ovf_b : ovf_a, e_ovf);
    end
    $display("op %s in=%h signed=%0d rtz=%0d res=%h inx=%0d ovf=%0d", tag, v, s, r,
             sel ? res_b : res_a, sel ? inx_b : inx_a, sel ? ovf_b : ovf_a);
  endtask

  logic [31:0] bp_op [6] = '{32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h181, 32'h183, 32'h3};
  logic        bp_s  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [17:0] bp_e  [6] = '{18'h03F80, 18'h0BF80, 18'h0CF00, 18'h143C0, 18'h143C2, 18'h04040};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ov", ov_a, 0);
    chk("rst.res", res_a, 0);
    chk("rst.inx", inx_a, 0);
    chk("rst.ovf", ovf_a, 0);
    chk("rst.res_b", res_b, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", ir_a, 1);

    // Directed conversions, bf16
    do_op(0, 32'h00000001, 1, 0, 16'h3F80, 0, 0, "one_s");
    do_op(0, 32'hFFFFFFFF, 1, 0, 16'hBF80, 0, 0, "m1_s");
    do_op(0, 32'h80000000, 1, 0, 16'hCF00, 0, 0, "minint_s");
    do_op(0, 32'h7FFFFFFF, 1, 0, 16'h4F00, 1, 0, "maxint_rne");
    do_op(0, 32'h7FFFFFFF, 1, 1, 16'h4EFF, 1, 0, "maxint_rtz");
    do_op(0, 32'hFFFFFFFF, 0, 0, 16'h4F80, 1, 0, "ffff_u_rne");
    do_op(0, 32'h00000181, 0, 0, 16'h43C0, 1, 0, "tie_even");
    do_op(0, 32'h00000183, 0, 0, 16'h43C2, 1, 0, "tie_up");
    do_op(0, 32'h00000000, 1, 0, 16'h0000, 0, 0, "zero_s");
    do_op(0, 32'h80000000, 0, 0, 16'h4F00, 0, 0, "msb_u");
    // Half-precision instance: overflow and largest finite
    do_op(1, 32'h00010000, 0, 0, 16'h7C00, 1, 1, "ovf_pos");
    do_op(1, 32'h80000000, 1, 0, 16'hFC00, 1, 1, "ovf_neg");
    do_op(1, 32'h0000FFFF, 0, 0, 16'h7C00, 1, 1, "ovf_carry");
    do_op(1, 32'h0000FFE0, 0, 0, 16'h7BFF, 0, 0, "max_finite");
    do_op(1, 32'h00000001, 0, 0, 16'h3C00, 0, 0, "one_h");

    // Backpressure: six back-to-back operands, consumer stalls in cycles 4..6
    repeat (4) @(posedge clk);
    begin
      int sent, rcv, cyc;
      logic [15:0] prev;
      logic prev_stall;
      sent = 0; rcv = 0; cyc = 0; prev = '0; prev_stall = 1'b0;
      while (rcv < 6 && cyc < 60) begin
        @(negedge clk);
        out_ready = !(cyc >= 4 && cyc <= 6);
        in_valid_a = (sent < 6);
        if (sent < 6) begin
          op = bp_op[sent]; sgn = bp_s[sent]; rtz = 1'b0;
        end
        #1;
        if (prev_stall) chk("bp.stable", res_a, prev);
        if (cyc == 4) begin
          chk("bp.ov_at_stall", ov_a, 1);
          chk("bp.in_ready", ir_a, 0);
        end
        if (ov_a && out_ready) begin
          chk($sformatf("bp.res%0d", rcv), {ovf_a, inx_a, res_a}, bp_e[rcv]);
          $display("bp result %0d res=%h inx=%0d", rcv, res_a, inx_a);
          rcv++;
        end
        if (in_valid_a && ir_a) sent++;
        prev_stall = ov_a && !out_ready;
        prev = res_a;
        cyc++;
      end
      in_valid_a = 1'b0;
      out_ready = 1'b1;
      chk("bp.count", rcv, 6);
      repeat (5) @(posedge clk);
      #1;
      chk("bp.nodup", ov_a, 0);
    end

    // Reset with three operations in flight
    begin
      int stale;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        in_valid_a = 1'b1; op = 32'(i + 5); sgn = 1'b0; rtz = 1'b0;
      end
      @(negedge clk);
      in_valid_a = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstmid.ov", ov_a, 0);
      chk("rstmid.res", res_a, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid.in_ready", ir_a, 1);
      stale = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (ov_a) stale++;
      end
      chk("rstmid.stale", stale, 0);
      $display("reset mid-stream stale_results=%0d", stale);
      do_op(0, 32'h00000005, 0, 0, 16'h40A0, 0, 0, "after_rst");
    end

    // Random valid/ready stream against the reference model
    repeat (4) @(posedge clk);
    begin
      int acc, cons, cyc;
      logic pend;
      logic [17:0] q[$];
      logic [17:0] e;
      acc = 0; cons = 0; cyc = 0; pend = 1'b0;
      while ((acc < 10000 || q.size() != 0) && cyc < 60000) begin
        @(negedge clk);
        if (!pend && acc < 10000 && $urandom_range(0, 3) != 0) begin
          pend = 1'b1;
          case ($urandom_range(0, 3))
            0: op = $urandom;
            1: op = 32'($urandom_range(0, 511));
            2: op = $urandom >> $urandom_range(0, 31);
            default: op = 32'h80000000 ^ 32'($urandom_range(0, 3)) ^ (32'($urandom_range(0, 1)) * 32'hFFFFFFFF);
          endcase
          sgn = 1'($urandom_range(0, 1));
          rtz = 1'($urandom_range(0, 1));
        end
        in_valid_a = pend;
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (ov_a && out_ready) begin
          if (q.size() == 0) chk("rnd.unexpected", 1, 0);
          else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d", cons), {ovf_a, inx_a, res_a}, e);
          end
          cons++;
        end
        if (in_valid_a && ir_a) begin
          q.push_back(model(op, sgn, rtz));
          acc++;
          pend = 1'b0;
        end
        cyc++;
      end
      in_valid_a = 1'b0;
      out_ready = 1'b1;
      chk("rnd.count", cons, 10000);
      $display("random stream accepted=%0d consumed=%0d cycles=%0d", acc, cons, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
